// File: rtl/phaethon_pkg.sv
// Shared Phaethon definitions: opcodes, fault codes, FSM encoding and opcode classifiers.
// The classifier functions are also used by the assembler tests, so keep them free of module state.
package phaethon_pkg;

    localparam logic [7:0] OP_LDI  = 8'd1;
    localparam logic [7:0] OP_LD   = 8'd2;
    localparam logic [7:0] OP_MOV  = 8'd3;
    localparam logic [7:0] OP_ST   = 8'd4;
    localparam logic [7:0] OP_CMP  = 8'd5;
    localparam logic [7:0] OP_JMP  = 8'd6;
    localparam logic [7:0] OP_LDX  = 8'd7;
    localparam logic [7:0] OP_STX  = 8'd8;
    localparam logic [7:0] OP_LDR  = 8'd9;
    localparam logic [7:0] OP_CMPI = 8'd10;
    localparam logic [7:0] OP_JNE  = 8'd11;
    localparam logic [7:0] OP_JE   = 8'd12;
    localparam logic [7:0] OP_JLT  = 8'd13;
    localparam logic [7:0] OP_JGT  = 8'd14;
    localparam logic [7:0] OP_ADDI = 8'd30;
    localparam logic [7:0] OP_DEC  = 8'd31;
    localparam logic [7:0] OP_ADD  = 8'd32;
    localparam logic [7:0] OP_SUB  = 8'd33;
    localparam logic [7:0] OP_AND  = 8'd34;
    localparam logic [7:0] OP_OR   = 8'd35;
    localparam logic [7:0] OP_XOR  = 8'd36;
    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam logic [1:0] FC_NONE       = 2'd0;
    localparam logic [1:0] FC_ILLEGAL    = 2'd1;
    localparam logic [1:0] FC_RD_TIMEOUT = 2'd2;
    localparam logic [1:0] FC_WR_TIMEOUT = 2'd3;

    // FETCH must stay 0 so the debug word reads 0 while in reset.
    typedef enum logic [7:0] {
        S_FETCH  = 8'd0,
        S_FWAIT  = 8'd1,
        S_DECODE = 8'd2,
        S_IREQ   = 8'd3,
        S_IWAIT  = 8'd4,
        S_MREQ   = 8'd5,
        S_MWAIT  = 8'd6,
        S_EXEC   = 8'd7,
        S_HALTED = 8'd8,
        S_FAULT  = 8'd9
    } state_t;

    function automatic logic Is8ByteOpcode(input logic [7:0] op);
        case (op)
            OP_LDI, OP_LD, OP_ST, OP_JMP, OP_LDX, OP_STX, OP_CMPI,
            OP_JNE, OP_JE, OP_JLT, OP_JGT, OP_ADDI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic IsRAMOpcode(input logic [7:0] op);
        case (op)
            OP_LD, OP_ST, OP_LDX, OP_STX, OP_LDR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic IsWriteOpcode(input logic [7:0] op);
        return (op == OP_ST) || (op == OP_STX);
    endfunction

    function automatic logic IsLegalOpcode(input logic [7:0] op);
        return ((op >= OP_LDI) && (op <= OP_JGT)) ||
               ((op >= OP_ADDI) && (op <= OP_XOR)) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/phaethon_exec_core_if.sv
// RAM request/acknowledge port: one-cycle req pulses out, ack (with read data) back.
interface phaethon_exec_core_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [DATA_W-1:0] ramIn;
    logic              readAck;
    logic              writeAck;
    logic [ADDR_W-1:0] ramAddress;
    logic [DATA_W-1:0] ramOut;
    logic              readReq;
    logic              writeReq;

    modport master (input ramIn, readAck, writeAck, output ramAddress, ramOut, readReq, writeReq);
    modport slave  (output ramIn, readAck, writeAck, input ramAddress, ramOut, readReq, writeReq);
endinterface

// File: rtl/phaethon_ack_timer.sv
// Ack wait counter: cleared by i_start, counts while i_run; o_expired flags the last allowed wait cycle.
// ACK_TIMEOUT of 0 disables expiry entirely.
module phaethon_ack_timer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_run,
    output logic o_expired
);
    generate
        if (ACK_TIMEOUT == 0) begin : g_off
            logic w_unused;
            assign w_unused  = clk ^ rst ^ i_start ^ i_run;
            assign o_expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(ACK_TIMEOUT + 1);
            logic [CW-1:0] r_count;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_count <= '0;
                end else if (i_start) begin
                    r_count <= '0;
                end else if (i_run && !o_expired) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Expired during the ACK_TIMEOUT-th wait cycle; an ack in that same cycle still wins.
            assign o_expired = i_run && (r_count == CW'(ACK_TIMEOUT - 1));
        end
    endgenerate
endmodule

// File: rtl/phaethon_exec_core.sv
// Multi-cycle fetch/decode/execute integer core on a single RAM req/ack port.
// 4/6/8 cycles per instruction with 1-cycle acks; waits indefinitely for acks unless ACK_TIMEOUT is set.
module phaethon_exec_core
    import phaethon_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_COUNT   = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    phaethon_exec_core_if.master  ram,
    output logic [ADDR_W-1:0]     ipointer,
    output logic [7:0]            opCode,
    output logic [2:0]            flags,
    output logic                  halted,
    output logic                  fault,
    output logic [1:0]            faultCode,
    output logic [31:0]           debug
);
    localparam int RIDX_W = $clog2(REG_COUNT);

    state_t              r_state, w_next;
    logic [7:0]          r_iop, r_op;
    logic [RIDX_W-1:0]   r_ia, r_ib, r_ic;
    logic [DATA_W-1:0]   r_k, r_mdata, r_va, r_vb, r_vc;
    logic [DATA_W-1:0]   r_regs [REG_COUNT];
    logic [2:0]          r_flags;
    logic [1:0]          r_fcode;
    logic [ADDR_W-1:0]   r_ip;

    logic                w_is_wr, w_start, w_run, w_expired;
    logic                w_rd_req, w_wr_req, w_wb, w_jump;
    logic [ADDR_W-1:0]   w_addr, w_maddr;
    logic [DATA_W-1:0]   w_res, w_cmp_rhs;

    assign w_is_wr = IsWriteOpcode(r_iop);
    assign w_start = (r_state == S_FETCH) || (r_state == S_IREQ) || (r_state == S_MREQ);
    assign w_run   = (r_state == S_FWAIT) || (r_state == S_IWAIT) || (r_state == S_MWAIT);

    phaethon_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (reset),
        .i_start   (w_start),
        .i_run     (w_run),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH:  w_next = S_FWAIT;
            S_FWAIT:  if (ram.readAck) w_next = S_DECODE;
                      else if (w_expired) w_next = S_FAULT;
            S_DECODE: if (!IsLegalOpcode(r_iop)) w_next = S_FAULT;
                      else if (Is8ByteOpcode(r_iop)) w_next = S_IREQ;
                      else if (IsRAMOpcode(r_iop)) w_next = S_MREQ;
                      else w_next = S_EXEC;
            S_IREQ:   w_next = S_IWAIT;
            S_IWAIT:  if (ram.readAck) w_next = IsRAMOpcode(r_iop) ? S_MREQ : S_EXEC;
                      else if (w_expired) w_next = S_FAULT;
            S_MREQ:   w_next = S_MWAIT;
            S_MWAIT:  if (w_is_wr ? ram.writeAck : ram.readAck) w_next = S_EXEC;
                      else if (w_expired) w_next = S_FAULT;
            S_EXEC:   w_next = (r_iop == OP_HALT) ? S_HALTED : S_FETCH;
            default:  w_next = r_state;
        endcase
    end

    always_comb begin
        case (r_iop)
            OP_LD, OP_ST: w_maddr = ADDR_W'(r_k);
            OP_LDX:       w_maddr = ADDR_W'(r_vb) + ADDR_W'(r_k);
            OP_STX:       w_maddr = ADDR_W'(r_va) + ADDR_W'(r_k);
            default:      w_maddr = ADDR_W'(r_vb);
        endcase
    end

    always_comb begin
        w_rd_req = 1'b0;
        w_wr_req = 1'b0;
        w_addr   = r_ip;
        case (r_state)
            S_FETCH: w_rd_req = 1'b1;
            S_IREQ:  begin w_rd_req = 1'b1; w_addr = r_ip + ADDR_W'(4); end
            S_IWAIT: w_addr = r_ip + ADDR_W'(4);
            S_MREQ:  begin w_rd_req = !w_is_wr; w_wr_req = w_is_wr; w_addr = w_maddr; end
            S_MWAIT: w_addr = w_maddr;
            default: ;
        endcase
    end

    // Reset parks the FSM in FETCH, whose request must not be visible while reset is held.
    assign ram.readReq    = w_rd_req && !reset;
    assign ram.writeReq   = w_wr_req && !reset;
    assign ram.ramAddress = w_addr;
    assign ram.ramOut     = (r_iop == OP_STX) ? r_vc : r_vb;

    always_comb begin
        w_res     = '0;
        w_wb      = 1'b1;
        w_jump    = 1'b0;
        w_cmp_rhs = (r_iop == OP_CMPI) ? r_k : r_vb;
        case (r_iop)
            OP_LDI:                w_res = r_k;
            OP_LD, OP_LDX, OP_LDR: w_res = r_mdata;
            OP_MOV:                w_res = r_vb;
            OP_ADDI:               w_res = r_va + r_k;
            OP_DEC:                w_res = r_va - DATA_W'(1);
            OP_ADD:                w_res = r_vb + r_vc;
            OP_SUB:                w_res = r_vb - r_vc;
            OP_AND:                w_res = r_vb & r_vc;
            OP_OR:                 w_res = r_vb | r_vc;
            OP_XOR:                w_res = r_vb ^ r_vc;
            default:               w_wb  = 1'b0;
        endcase
        case (r_iop)
            OP_JMP:  w_jump = 1'b1;
            OP_JNE:  w_jump = !r_flags[0];
            OP_JE:   w_jump = r_flags[0];
            OP_JLT:  w_jump = r_flags[1];
            OP_JGT:  w_jump = r_flags[2];
            default: w_jump = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_iop   <= '0;
            r_op    <= '0;
            r_ia    <= '0;
            r_ib    <= '0;
            r_ic    <= '0;
            r_k     <= '0;
            r_mdata <= '0;
            r_va    <= '0;
            r_vb    <= '0;
            r_vc    <= '0;
            r_flags <= '0;
            r_fcode <= FC_NONE;
            r_ip    <= '0;
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else begin
            if (r_state == S_FWAIT && ram.readAck) begin
                r_iop <= ram.ramIn[7:0];
                r_ia  <= ram.ramIn[8 +: RIDX_W];
                r_ib  <= ram.ramIn[16 +: RIDX_W];
                r_ic  <= ram.ramIn[24 +: RIDX_W];
            end
            if (r_state == S_DECODE) begin
                r_op <= r_iop;
                r_va <= r_regs[r_ia];
                r_vb <= r_regs[r_ib];
                r_vc <= r_regs[r_ic];
            end
            if (r_state == S_IWAIT && ram.readAck) r_k <= ram.ramIn;
            if (r_state == S_MWAIT && ram.readAck && !w_is_wr) r_mdata <= ram.ramIn;
            if (w_next == S_FAULT && r_state != S_FAULT) begin
                if (r_state == S_DECODE)                 r_fcode <= FC_ILLEGAL;
                else if (r_state == S_MWAIT && w_is_wr)  r_fcode <= FC_WR_TIMEOUT;
                else                                     r_fcode <= FC_RD_TIMEOUT;
            end
            if (r_state == S_EXEC) begin
                if (w_wb) r_regs[r_ia] <= w_res;
                if (r_iop == OP_CMP || r_iop == OP_CMPI)
                    r_flags <= {r_va > w_cmp_rhs, r_va < w_cmp_rhs, r_va == w_cmp_rhs};
                r_ip <= w_jump ? ADDR_W'(r_k)
                               : r_ip + (Is8ByteOpcode(r_iop) ? ADDR_W'(8) : ADDR_W'(4));
            end
        end
    end

    assign ipointer  = r_ip;
    assign opCode    = r_op;
    assign flags     = r_flags;
    assign halted    = (r_state == S_HALTED);
    assign fault     = (r_state == S_FAULT);
    assign faultCode = r_fcode;
    assign debug     = {r_state, 24'(r_ip)};
endmodule
